adaptive_threshold_sequencer: RTL and testbench

- Top-level controller for the adaptive-thresholding pipeline.
- Drives the shared `global_state` bus and a per-stage active-low clear. Sequences start → box filter → threshold → done, and muxes the shared image-memory address between the active stage and the display reader.
- Adds a per-stage watchdog timeout, abort handling and a run-cycle counter.

---
 rtl/adaptive_threshold_sequencer_if.sv | 44 ++++
 rtl/adaptive_threshold_sequencer.sv | 159 +++++++++++++++
 tb/tb_adaptive_threshold_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adaptive_threshold_sequencer_if.sv
// Bus between the adaptive-threshold sequencer and the rest of the pipeline:
// run control, per-stage finished flags, the three image address sources,
// and the status / shared-address outputs of the sequencer.
interface adaptive_threshold_sequencer_if #(
    parameter int WIDTH_BITS  = 8,
    parameter int HEIGHT_BITS = 8,
    parameter int CNT_BITS    = 24
);
    logic                   iStart;
    logic                   iAbort;
    logic                   iBoxFinished;
    logic                   iThreshFinished;
    logic [WIDTH_BITS-1:0]  iBoxCol;
    logic [HEIGHT_BITS-1:0] iBoxRow;
    logic [WIDTH_BITS-1:0]  iThCol;
    logic [HEIGHT_BITS-1:0] iThRow;
    logic [WIDTH_BITS-1:0]  iDispCol;
    logic [HEIGHT_BITS-1:0] iDispRow;

    logic [2:0]             global_state;
    logic                   oStageRst_n;
    logic [WIDTH_BITS-1:0]  oMemCol;
    logic [HEIGHT_BITS-1:0] oMemRow;
    logic                   oBusy;
    logic                   oDone;
    logic                   oError;
    logic [CNT_BITS-1:0]    oCycleCount;

    // Pipeline side: drives requests, flags and addresses, observes status.
    modport master (
        output iStart, iAbort, iBoxFinished, iThreshFinished,
        output iBoxCol, iBoxRow, iThCol, iThRow, iDispCol, iDispRow,
        input  global_state, oStageRst_n, oMemCol, oMemRow,
        input  oBusy, oDone, oError, oCycleCount
    );

    // Sequencer side.
    modport slave (
        input  iStart, iAbort, iBoxFinished, iThreshFinished,
        input  iBoxCol, iBoxRow, iThCol, iThRow, iDispCol, iDispRow,
        output global_state, oStageRst_n, oMemCol, oMemRow,
        output oBusy, oDone, oError, oCycleCount
    );
endinterface

// File: rtl/adaptive_threshold_sequencer.sv
// Top-level controller of the adaptive-thresholding pipeline. Walks the run
// through clear -> box filter -> clear -> threshold -> done, drives the shared
// global_state bus and the stage clear, guards each stage with a watchdog,
// counts run cycles and steers the shared image-memory address.
module adaptive_threshold_sequencer #(
    parameter int WIDTH_BITS     = 8,
    parameter int HEIGHT_BITS    = 8,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int CNT_BITS       = 24
) (
    input  logic                          clock,
    input  logic                          reset,
    adaptive_threshold_sequencer_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR_BOX,
        S_BOX,
        S_BOX_DRAIN,
        S_CLR_TH,
        S_TH,
        S_TH_DRAIN,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [CNT_BITS-1:0] WD_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);

    state_t                 state;
    state_t                 next_state;
    logic                   clr_second;
    logic [CNT_BITS-1:0]    watchdog;
    logic [CNT_BITS-1:0]    cycle_count;
    logic [2:0]             state_code;
    logic                   stage_rst_n;
    logic                   busy;
    logic                   done;
    logic                   error;
    logic                   wd_expired;
    logic [WIDTH_BITS-1:0]  mem_col;
    logic [HEIGHT_BITS-1:0] mem_row;

    // Value the shared global_state bus carries for each internal state;
    // the clear and drain states share the code of their neighbours.
    function automatic logic [2:0] encode(input state_t s);
        case (s)
            S_BOX, S_BOX_DRAIN: encode = 3'd1;
            S_TH, S_TH_DRAIN:   encode = 3'd2;
            S_DONE:             encode = 3'd3;
            S_ERROR:            encode = 3'd4;
            default:            encode = 3'd0;
        endcase
    endfunction

    // States that belong to an active run and therefore count cycles.
    function automatic logic is_running(input state_t s);
        is_running = (s == S_CLR_BOX) || (s == S_BOX) || (s == S_BOX_DRAIN) ||
                     (s == S_CLR_TH)  || (s == S_TH)  || (s == S_TH_DRAIN);
    endfunction

    assign wd_expired = (watchdog == WD_LAST);

    // Next-state decision; abort beats start, finished flags and timeout.
    always_comb begin
        next_state = state;
        if (bus.iAbort) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE:      if (bus.iStart) next_state = S_CLR_BOX;
                S_CLR_BOX:   if (clr_second) next_state = S_BOX;
                S_BOX: begin
                    if (bus.iBoxFinished)  next_state = S_BOX_DRAIN;
                    else if (wd_expired)   next_state = S_ERROR;
                end
                S_BOX_DRAIN: next_state = S_CLR_TH;
                S_CLR_TH:    if (clr_second) next_state = S_TH;
                S_TH: begin
                    if (bus.iThreshFinished) next_state = S_TH_DRAIN;
                    else if (wd_expired)     next_state = S_ERROR;
                end
                S_TH_DRAIN:  next_state = S_DONE;
                S_DONE:      if (bus.iStart) next_state = S_CLR_BOX;
                S_ERROR:     next_state = S_ERROR;
                default:     next_state = S_IDLE;
            endcase
        end
    end

    // State register plus every registered output, decoded from the next state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            clr_second  <= 1'b0;
            watchdog    <= '0;
            cycle_count <= '0;
            state_code  <= 3'd0;
            stage_rst_n <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            state      <= next_state;
            clr_second <= (next_state == state) &&
                          ((state == S_CLR_BOX) || (state == S_CLR_TH));

            if (next_state != state)
                watchdog <= '0;
            else if ((state == S_BOX) || (state == S_TH))
                watchdog <= watchdog + 1'b1;

            if (next_state == S_IDLE)
                cycle_count <= '0;
            else if ((next_state == S_CLR_BOX) && ((state == S_IDLE) || (state == S_DONE)))
                cycle_count <= '0;
            else if (is_running(state) && (cycle_count != '1))
                cycle_count <= cycle_count + 1'b1;

            state_code  <= encode(next_state);
            stage_rst_n <= !((next_state == S_IDLE) || (next_state == S_CLR_BOX) ||
                             (next_state == S_CLR_TH) || (next_state == S_ERROR));
            busy        <= !((next_state == S_IDLE) || (next_state == S_DONE) ||
                             (next_state == S_ERROR));
            done        <= (next_state == S_DONE);
            error       <= (next_state == S_ERROR);
        end
    end

    // Shared image-memory address follows whichever stage global_state names.
    always_comb begin
        mem_col = bus.iDispCol;
        mem_row = bus.iDispRow;
        case (state_code)
            3'd1: begin
                mem_col = bus.iBoxCol;
                mem_row = bus.iBoxRow;
            end
            3'd2: begin
                mem_col = bus.iThCol;
                mem_row = bus.iThRow;
            end
            default: begin
                mem_col = bus.iDispCol;
                mem_row = bus.iDispRow;
            end
        endcase
    end

    assign bus.global_state = state_code;
    assign bus.oStageRst_n  = stage_rst_n;
    assign bus.oBusy        = busy;
    assign bus.oDone        = done;
    assign bus.oError       = error;
    assign bus.oCycleCount  = cycle_count;
    assign bus.oMemCol      = mem_col;
    assign bus.oMemRow      = mem_row;

endmodule

// File: tb/tb_adaptive_threshold_sequencer.sv
// Self-checking bench for adaptive_threshold_sequencer. Expected behaviour of
// a run is derived from the stage durations with plain arithmetic on the
// cycle index counted from the CLR_BOX entry.
module tb_adaptive_threshold_sequencer;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int CB = 24;
    localparam int TO = 16;

    localparam logic [7:0] BOX_COL  = 8'h1A;
    localparam logic [7:0] BOX_ROW  = 8'h2B;
    localparam logic [7:0] TH_COL   = 8'h3C;
    localparam logic [7:0] TH_ROW   = 8'h4D;
    localparam logic [7:0] DISP_COL = 8'h5E;
    localparam logic [7:0] DISP_ROW = 8'h6F;

    logic clock = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    adaptive_threshold_sequencer_if #(.WIDTH_BITS(W), .HEIGHT_BITS(H), .CNT_BITS(CB)) bus();

    adaptive_threshold_sequencer #(
        .WIDTH_BITS(W), .HEIGHT_BITS(H), .TIMEOUT_CYCLES(TO), .CNT_BITS(CB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    // Advance one clock and land just after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // {global_state, oStageRst_n, oBusy, oDone, oError} as one vector.
    function automatic logic [6:0] pack_ctrl(input int gs, input bit rn, input bit bz,
                                             input bit dn, input bit er);
        logic [2:0] g;
        g = gs[2:0];
        pack_ctrl = {g, rn, bz, dn, er};
    endfunction

    function automatic logic [15:0] addr_for(input int gs);
        if (gs == 1)      addr_for = {BOX_ROW, BOX_COL};
        else if (gs == 2) addr_for = {TH_ROW, TH_COL};
        else              addr_for = {DISP_ROW, DISP_COL};
    endfunction

    function automatic logic [6:0] actual_ctrl();
        actual_ctrl = {bus.global_state, bus.oStageRst_n, bus.oBusy, bus.oDone, bus.oError};
    endfunction

    task automatic test_reset();
        logic [6:0] exp_c;
        reset = 1'b1;
        bus.iStart = 1'b0; bus.iAbort = 1'b0;
        bus.iBoxFinished = 1'b0; bus.iThreshFinished = 1'b0;
        bus.iBoxCol = BOX_COL;   bus.iBoxRow = BOX_ROW;
        bus.iThCol = TH_COL;     bus.iThRow = TH_ROW;
        bus.iDispCol = DISP_COL; bus.iDispRow = DISP_ROW;
        #3;
        exp_c = pack_ctrl(0, 0, 0, 0, 0);
        checks++;
        if (actual_ctrl() !== exp_c) begin
            errors++;
            $display("[TB] FAIL reset_ctrl actual=%b required=%b", actual_ctrl(), exp_c);
        end
        checks++;
        if (bus.oCycleCount !== 24'd0) begin
            errors++;
            $display("[TB] FAIL reset_count actual=%0d required=0", bus.oCycleCount);
        end
        checks++;
        if ({bus.oMemRow, bus.oMemCol} !== addr_for(0)) begin
            errors++;
            $display("[TB] FAIL reset_addr actual=%h required=%h", {bus.oMemRow, bus.oMemCol}, addr_for(0));
        end
        tick();
        @(negedge clock);
        reset = 1'b0;
        tick();
        checks++;
        if (actual_ctrl() !== exp_c) begin
            errors++;
            $display("[TB] FAIL idle_after_reset actual=%b required=%b", actual_ctrl(), exp_c);
        end
    endtask

    task automatic test_start_abort_priority();
        logic [6:0] exp_c;
        exp_c = pack_ctrl(0, 0, 0, 0, 0);
        bus.iStart = 1'b1;
        bus.iAbort = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (actual_ctrl() !== exp_c) begin
                errors++;
                $display("[TB] FAIL abort_over_start i=%0d actual=%b required=%b", i, actual_ctrl(), exp_c);
            end
        end
        bus.iStart = 1'b0;
        bus.iAbort = 1'b0;
    endtask

    // One complete run: box finishes in its nb-th cycle, threshold in its nt-th.
    // With stale set, both flags stay high from the previous run through the
    // clear phases where the sequencer must ignore them.
    task automatic test_full_run(input int nb, input int nt, input bit stale, input string name);
        int last;
        int gs;
        bit rn;
        logic [6:0] exp_c;
        logic [23:0] exp_cnt;
        last = 6 + nb + nt;
        if (!stale) begin
            bus.iBoxFinished = 1'b0;
            bus.iThreshFinished = 1'b0;
        end
        bus.iStart = 1'b1;
        tick();
        bus.iStart = 1'b0;
        for (int c = 0; c <= last + 2; c++) begin
            if (c < 2)                gs = 0;
            else if (c <= 2 + nb)     gs = 1;
            else if (c < 5 + nb)      gs = 0;
            else if (c <= 5 + nb + nt) gs = 2;
            else                      gs = 3;
            rn = !((c < 2) || ((c >= 3 + nb) && (c <= 4 + nb)));
            exp_c = pack_ctrl(gs, rn, c < last, c >= last, 0);
            exp_cnt = 24'((c < last) ? c : last);
            checks++;
            if (actual_ctrl() !== exp_c) begin
                errors++;
                $display("[TB] FAIL %s_ctrl c=%0d actual=%b required=%b", name, c, actual_ctrl(), exp_c);
            end
            checks++;
            if (bus.oCycleCount !== exp_cnt) begin
                errors++;
                $display("[TB] FAIL %s_count c=%0d actual=%0d required=%0d", name, c, bus.oCycleCount, exp_cnt);
            end
            checks++;
            if ({bus.oMemRow, bus.oMemCol} !== addr_for(gs)) begin
                errors++;
                $display("[TB] FAIL %s_addr c=%0d actual=%h required=%h", name, c, {bus.oMemRow, bus.oMemCol}, addr_for(gs));
            end
            bus.iBoxFinished    = (c >= 1 + nb) || (stale && c < 2);
            bus.iThreshFinished = (c >= 4 + nb + nt) || (stale && c < 5 + nb);
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int nb;
        int nt;
        for (int r = 0; r < 2; r++) begin
            nb = int'($urandom_range(1, 12));
            nt = int'($urandom_range(1, 12));
            test_full_run(nb, nt, 1'b1, "b2b");
        end
    endtask

    task automatic test_watchdog();
        logic [6:0] exp_c;
        bus.iBoxFinished = 1'b0;
        bus.iThreshFinished = 1'b0;
        bus.iStart = 1'b1;
        tick();
        bus.iStart = 1'b0;
        for (int c = 0; c < 2 + TO; c++) begin
            exp_c = pack_ctrl((c < 2) ? 0 : 1, c >= 2, 1, 0, 0);
            checks++;
            if (actual_ctrl() !== exp_c) begin
                errors++;
                $display("[TB] FAIL wd_run c=%0d actual=%b required=%b", c, actual_ctrl(), exp_c);
            end
            tick();
        end
        exp_c = pack_ctrl(4, 0, 0, 0, 1);
        checks++;
        if (actual_ctrl() !== exp_c) begin
            errors++;
            $display("[TB] FAIL wd_error actual=%b required=%b", actual_ctrl(), exp_c);
        end
        checks++;
        if (bus.oCycleCount !== 24'(2 + TO)) begin
            errors++;
            $display("[TB] FAIL wd_count actual=%0d required=%0d", bus.oCycleCount, 2 + TO);
        end
        bus.iStart = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ((actual_ctrl() !== exp_c) || (bus.oCycleCount !== 24'(2 + TO))) begin
                errors++;
                $display("[TB] FAIL wd_start_ignored i=%0d actual=%b/%0d required=%b/%0d",
                         i, actual_ctrl(), bus.oCycleCount, exp_c, 2 + TO);
            end
        end
        bus.iStart = 1'b0;
        bus.iAbort = 1'b1;
        tick();
        bus.iAbort = 1'b0;
        exp_c = pack_ctrl(0, 0, 0, 0, 0);
        checks++;
        if ((actual_ctrl() !== exp_c) || (bus.oCycleCount !== 24'd0)) begin
            errors++;
            $display("[TB] FAIL wd_abort actual=%b/%0d required=%b/0", actual_ctrl(), bus.oCycleCount, exp_c);
        end
    endtask

    // Abort k cycles into the threshold stage, with its finished flag raised
    // in the same cycle to show abort still wins.
    task automatic test_abort_in_th(input int nb, input int k);
        logic [6:0] exp_c;
        bus.iBoxFinished = 1'b0;
        bus.iThreshFinished = 1'b0;
        bus.iStart = 1'b1;
        tick();
        bus.iStart = 1'b0;
        for (int c = 0; c < 5 + nb + k; c++) begin
            bus.iBoxFinished = (c >= 1 + nb);
            tick();
        end
        checks++;
        if ((bus.global_state !== 3'd2) || ({bus.oMemRow, bus.oMemCol} !== addr_for(2))) begin
            errors++;
            $display("[TB] FAIL abort_pre_th actual=%0d/%h required=2/%h",
                     bus.global_state, {bus.oMemRow, bus.oMemCol}, addr_for(2));
        end
        bus.iAbort = 1'b1;
        bus.iThreshFinished = 1'b1;
        tick();
        bus.iAbort = 1'b0;
        bus.iThreshFinished = 1'b0;
        bus.iBoxFinished = 1'b0;
        exp_c = pack_ctrl(0, 0, 0, 0, 0);
        checks++;
        if ((actual_ctrl() !== exp_c) || (bus.oCycleCount !== 24'd0)) begin
            errors++;
            $display("[TB] FAIL abort_th_ctrl actual=%b/%0d required=%b/0", actual_ctrl(), bus.oCycleCount, exp_c);
        end
        checks++;
        if ({bus.oMemRow, bus.oMemCol} !== addr_for(0)) begin
            errors++;
            $display("[TB] FAIL abort_th_addr actual=%h required=%h", {bus.oMemRow, bus.oMemCol}, addr_for(0));
        end
    endtask

    task automatic test_reset_mid_run();
        logic [6:0] exp_c;
        bus.iBoxFinished = 1'b0;
        bus.iThreshFinished = 1'b0;
        bus.iStart = 1'b1;
        tick();
        bus.iStart = 1'b0;
        repeat (4) tick();
        checks++;
        if (bus.global_state !== 3'd1) begin
            errors++;
            $display("[TB] FAIL midreset_in_box actual=%0d required=1", bus.global_state);
        end
        #2;
        reset = 1'b1;
        #1;
        exp_c = pack_ctrl(0, 0, 0, 0, 0);
        checks++;
        if ((actual_ctrl() !== exp_c) || (bus.oCycleCount !== 24'd0) ||
            ({bus.oMemRow, bus.oMemCol} !== addr_for(0))) begin
            errors++;
            $display("[TB] FAIL midreset_async actual=%b/%0d/%h required=%b/0/%h",
                     actual_ctrl(), bus.oCycleCount, {bus.oMemRow, bus.oMemCol}, exp_c, addr_for(0));
        end
        @(negedge clock);
        reset = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_start_abort_priority();
        test_full_run(int'($urandom_range(1, 12)), int'($urandom_range(1, 12)), 1'b0, "run_rand");
        test_full_run(TO, TO, 1'b0, "run_wd_edge");
        test_full_run(1, 1, 1'b0, "run_min");
        test_back_to_back();
        bus.iStart = 1'b0;
        bus.iAbort = 1'b1;
        tick();
        bus.iAbort = 1'b0;
        test_watchdog();
        test_abort_in_th(int'($urandom_range(1, 10)), int'($urandom_range(0, 10)));
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
